// File: rtl/pulse_deserializer8.sv
// pulse_deserializer8
//   Receive-side partner of the 8-bit load-then-shift pulse generator.
//   After a START strobe in IDLE, samples WIDTH bits of SIN on successive
//   rising edges of CLK and assembles them into a parallel word. The word
//   is offered on OUT with a VALID/ACK handshake. MATCH reports whether the
//   accepted word equalled PATTERN. OVERRUN is a sticky flag: it is set when
//   a completed frame had to be dropped because the previous word was still
//   waiting for ACK.
//
// Parameters
//   WIDTH      bits per frame, width of OUT/PATTERN (>= 2)
//   MSB_FIRST  1: first bit received lands in OUT[WIDTH-1]; 0: lands in OUT[0]
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous, active-high reset
//   SIN      in   serial data, sampled while BUSY
//   START    in   frame start strobe, honoured only in IDLE
//   PATTERN  in   compare word, sampled on the frame-completion edge
//   OUT      out  last accepted word (registered)
//   VALID    out  OUT holds an unacknowledged word
//   ACK      in   consumer takes OUT on a rising edge while VALID=1
//   BUSY     out  frame capture in progress
//   MATCH    out  accepted word equalled PATTERN (qualified by VALID)
//   OVERRUN  out  sticky: a completed frame was dropped

module pulse_deserializer8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SIN,
  input  logic             START,
  input  logic [WIDTH-1:0] PATTERN,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID,
  input  logic             ACK,
  output logic             BUSY,
  output logic             MATCH,
  output logic             OVERRUN
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;
  logic             match_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shift_d;
  logic             frame_done;
  logic             space_ok;

  // Shift register contents after sampling SIN on this edge. On the
  // completion edge this is the full word, including the final bit.
  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], SIN};
    end else begin
      shift_d = {SIN, shift_q[WIDTH-1:1]};
    end
  end

  assign frame_done = (state_q == ST_SHIFT) && (cnt_q == LAST);
  // An ACK on the completion edge frees the output slot in the same cycle.
  assign space_ok   = !valid_q || ACK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // No data is sampled on the START edge itself.
          if (START) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          // START is deliberately ignored for the whole frame.
          shift_q <= shift_d;
          if (cnt_q == LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase

      if (frame_done) begin
        if (space_ok) begin
          out_q   <= shift_d;
          valid_q <= 1'b1;
          match_q <= (shift_d == PATTERN);
        end else begin
          // Previous word still pending: drop the new one, keep OUT intact.
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ACK) begin
        valid_q <= 1'b0;
        match_q <= 1'b0;
      end
    end
  end

  assign OUT     = out_q;
  assign VALID   = valid_q;
  assign MATCH   = match_q;
  assign OVERRUN = overrun_q;
  assign BUSY    = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_pulse_deserializer8.sv
// Directed testbench for pulse_deserializer8. Two instances share all
// inputs: dut_m receives MSB first, dut_l receives LSB first.

module tb_pulse_deserializer8;

  logic       CLK;
  logic       RESET;
  logic       SIN;
  logic       START;
  logic [7:0] PATTERN;
  logic       ACK;

  logic [7:0] out_m, out_l;
  logic       valid_m, valid_l;
  logic       busy_m, busy_l;
  logic       match_m, match_l;
  logic       ovr_m, ovr_l;

  int passed = 0;
  int total  = 0;

  pulse_deserializer8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .START(START), .PATTERN(PATTERN),
    .OUT(out_m), .VALID(valid_m), .ACK(ACK), .BUSY(busy_m),
    .MATCH(match_m), .OVERRUN(ovr_m)
  );

  pulse_deserializer8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RESET(RESET), .SIN(SIN), .START(START), .PATTERN(PATTERN),
    .OUT(out_l), .VALID(valid_l), .ACK(ACK), .BUSY(busy_l),
    .MATCH(match_l), .OVERRUN(ovr_l)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // bits[7] is sent first. start_mask[k] drives START alongside bit k
  // (k = 7 first). ack_last drives ACK on the completion edge.
  task automatic frame(input logic [7:0] bits, input logic [7:0] start_mask,
                       input logic ack_last);
    START = 1'b1;
    tick();
    for (int k = 7; k >= 0; k--) begin
      SIN   = bits[k];
      START = start_mask[k];
      ACK   = (k == 0) ? ack_last : 1'b0;
      tick();
    end
    START = 1'b0;
    ACK   = 1'b0;
    SIN   = 1'b0;
  endtask

  task automatic do_ack;
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask

  initial begin
    RESET   = 1'b1;
    SIN     = 1'b0;
    START   = 1'b0;
    ACK     = 1'b0;
    PATTERN = 8'hF0;

    // Reset and idle with SIN toggling
    tick();
    chk("rst_out", out_m, 8'h00);
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SIN = i[0];
      tick();
      chk("idle_out", out_m, 8'h00);
      chk("idle_valid", valid_m, 1'b0);
      chk("idle_busy", busy_m, 1'b0);
      chk("idle_match", match_m, 1'b0);
      chk("idle_ovr", ovr_m, 1'b0);
    end

    // Basic MSB-first frame with BUSY timing
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("busy_after_e0", busy_m, 1'b1);
    for (int k = 7; k >= 1; k--) begin
      SIN = (k >= 4);
      tick();
    end
    chk("busy_after_e7", busy_m, 1'b1);
    chk("valid_before_e8", valid_m, 1'b0);
    SIN = 1'b0;
    tick();
    chk("basic_out", out_m, 8'hF0);
    chk("basic_valid", valid_m, 1'b1);
    chk("basic_match", match_m, 1'b1);
    chk("basic_busy", busy_m, 1'b0);
    chk("basic_lsbfirst_out", out_l, 8'h0F);
    do_ack();
    chk("ack_valid", valid_m, 1'b0);
    chk("ack_match", match_m, 1'b0);
    chk("ack_out_hold", out_m, 8'hF0);
    // ACK with VALID=0 does nothing
    do_ack();
    chk("ack_idle_out", out_m, 8'hF0);
    chk("ack_idle_valid", valid_m, 1'b0);

    // LSB-first mismatch
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    PATTERN = 8'hF0;
    frame(8'b1010_0000, 8'h00, 1'b0);
    chk("lsb_out", out_l, 8'h05);
    chk("lsb_match", match_l, 1'b0);
    chk("lsb_valid", valid_l, 1'b1);
    chk("msb_same_bits_out", out_m, 8'hA0);
    do_ack();

    // Overrun
    frame(8'hA5, 8'h00, 1'b0);
    chk("ovr_first_out", out_m, 8'hA5);
    chk("ovr_first_flag", ovr_m, 1'b0);
    frame(8'h3C, 8'h00, 1'b0);
    chk("ovr_out_kept", out_m, 8'hA5);
    chk("ovr_valid", valid_m, 1'b1);
    chk("ovr_flag", ovr_m, 1'b1);
    do_ack();
    chk("ovr_after_ack_valid", valid_m, 1'b0);
    chk("ovr_sticky", ovr_m, 1'b1);
    PATTERN = 8'h11;
    frame(8'h11, 8'h00, 1'b0);
    chk("ovr_third_out", out_m, 8'h11);
    chk("ovr_third_valid", valid_m, 1'b1);
    chk("ovr_third_match", match_m, 1'b1);
    chk("ovr_still_sticky", ovr_m, 1'b1);
    do_ack();

    // ACK coinciding with completion
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    PATTERN = 8'h3C;
    frame(8'hA5, 8'h00, 1'b0);
    chk("sim_first_out", out_m, 8'hA5);
    chk("sim_first_match", match_m, 1'b0);
    frame(8'h3C, 8'h00, 1'b1);
    chk("sim_out", out_m, 8'h3C);
    chk("sim_valid", valid_m, 1'b1);
    chk("sim_match", match_m, 1'b1);
    chk("sim_ovr", ovr_m, 1'b0);
    do_ack();

    // START pulses during bits 2-3 are ignored
    PATTERN = 8'hF0;
    frame(8'h96, 8'b0110_0000, 1'b0);
    chk("ign_start_out", out_m, 8'h96);
    chk("ign_start_busy", busy_m, 1'b0);
    chk("ign_start_valid", valid_m, 1'b1);

    // Reset after bit 4 of a frame, word 8'h96 still pending
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) begin
      SIN = 1'b1;
      tick();
    end
    chk("mid_busy_pre", busy_m, 1'b1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_busy", busy_m, 1'b0);
    chk("mid_rst_valid", valid_m, 1'b0);
    chk("mid_rst_out", out_m, 8'h00);
    RESET = 1'b0;
    SIN = 1'b0;
    tick();
    frame(8'h5A, 8'h00, 1'b0);
    chk("fresh_out", out_m, 8'h5A);
    chk("fresh_valid", valid_m, 1'b1);
    chk("fresh_match", match_m, 1'b0);
    chk("fresh_ovr", ovr_m, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pulse_deserializer8.md
Name: pulse_deserializer8

Overview:
- Receive-side counterpart to the 8-bit pulse generator (load-then-shift serial source on CLK).
- Samples the generator's serial Q stream after a START strobe and assembles WIDTH bits into a parallel word.
- Presents the word with a VALID/ACK handshake, flags a pattern match and records overruns.
- Sits directly downstream of the pulse generator; generator LOAD drives START, generator Q drives SIN.

Parameters:
WIDTH, 8, bits per frame and width of OUT/PATTERN (min 2)
MSB_FIRST, 1, 1: first received bit lands in OUT[WIDTH-1]; 0: first bit lands in OUT[0]

Ports:
CLK  input  1  system clock, all state changes on rising edge
RESET  input  1  asynchronous, active-high reset
SIN  input  1  serial data bit, sampled on rising CLK while BUSY
START  input  1  frame start strobe, sampled on rising CLK in IDLE only
PATTERN  input  WIDTH  compare word, sampled on the frame-completion edge
OUT  output  WIDTH  last accepted word (registered)
VALID  output  1  OUT holds an unacknowledged word
ACK  input  1  consumer accepts OUT; effective on a rising edge while VALID=1
BUSY  output  1  frame capture in progress (state SHIFT)
MATCH  output  1  accepted word equalled PATTERN; qualified by VALID
OVERRUN  output  1  sticky: a completed frame was dropped

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high on RESET: state=IDLE, bit counter=0, shift reg=0, OUT=0, VALID=0, BUSY=0, MATCH=0, OVERRUN=0.
- FSM: two states, IDLE and SHIFT. BUSY=1 exactly in SHIFT, decoded from registered state.
- IDLE:
  - START=1 at an edge -> SHIFT, counter=0. No data is sampled on the START edge.
  - START=0 -> stay in IDLE. SIN is ignored.
- SHIFT:
  - Each edge samples SIN into the shift reg and increments the counter.
  - MSB_FIRST=1: shift left, new bit enters LSB. MSB_FIRST=0: shift right, new bit enters MSB.
  - Frame completes on the edge that samples bit WIDTH-1 (counter==WIDTH-1). On that edge -> IDLE, counter=0.
  - START is ignored throughout SHIFT, including the completion edge.
- Latency: START sampled at edge E0. Bits are sampled at E1..E_WIDTH. OUT/VALID/MATCH update at E_WIDTH and are visible after it.
- Minimum frame spacing is WIDTH+1 edges. The next START can be sampled at E_WIDTH+1 at the earliest.
- Completion edge, space available (VALID=0, or VALID=1 and ACK=1):
  - OUT <= assembled word (including the bit sampled on this edge).
  - VALID <= 1.
  - MATCH <= (word == PATTERN).
- Completion edge, no space (VALID=1 and ACK=0):
  - Word is discarded. OUT, VALID and MATCH are unchanged. OVERRUN <= 1.
- Non-completion edge with VALID=1 and ACK=1: VALID <= 0, MATCH <= 0.
- ACK while VALID=0 has no effect.
- OVERRUN stays set until RESET.
- RESET asserted mid-frame aborts capture. Partial bits are discarded and the outputs take their reset values immediately, without waiting for an edge.
- SIN, START, PATTERN and ACK are synchronous to CLK. No internal synchronizers.

Test Plan:
- Reset/idle: assert RESET, then release; clock 5 cycles with START=0 and SIN toggling -> OUT=8'h00, VALID=0, BUSY=0, MATCH=0, OVERRUN=0 throughout.
- Basic frame, MSB_FIRST=1: START at E0; SIN=1,1,1,1,0,0,0,0 on E1..E8; PATTERN=8'hF0 -> BUSY=1 after E0 through E7, OUT=8'hF0, VALID=1, MATCH=1 after E8, BUSY=0 after E8. Hold ACK=1 for one edge -> VALID=0, MATCH=0, OUT stays 8'hF0.
- Mismatch, MSB_FIRST=0: bits 1,0,1,0,0,0,0,0; PATTERN=8'hF0 -> OUT=8'h05, MATCH=0, VALID=1.
- Overrun: frame 8'hA5 left unacknowledged, then frame 8'h3C completes with ACK=0 -> OUT stays 8'hA5, VALID=1, OVERRUN=1. OVERRUN stays 1 after a later ACK. A third frame 8'h11 is then accepted normally.
- Simultaneous ACK and completion: VALID=1 (8'hA5), ACK=1 on the completion edge of frame 8'h3C -> OUT=8'h3C, VALID stays 1, OVERRUN=0.
- Reset mid-frame and ignored START: START pulses during bits 2-3 do not restart the frame (OUT correct after E8). A separate frame with RESET asserted after bit 4 -> BUSY, VALID and OUT clear immediately. After release, a fresh frame yields a clean word with no residue from the partial frame.
